// File: rtl/axis_downsizer_if.sv
// AXI4-Stream bundle used on both sides of axis_downsizer.
//   tdata  [DATA_WIDTH]    payload
//   tkeep  [DATA_WIDTH/8]  byte qualifiers
//   tvalid / tready        handshake
//   tlast                  end of packet
//   tuser  [USER_WIDTH]    sideband
// master modport drives payload/valid and samples ready; slave is the mirror.
interface axis_downsizer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int USER_WIDTH = 1
) ();
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// AXI4-Stream width down-converter: one wide input word per handshake is
// emitted as narrow beats, lowest segment first.
// Ports:
//   clk     rising-edge clock
//   arst    asynchronous reset, active high
//   s_axis  wide input stream  (S_DATA_WIDTH)
//   m_axis  narrow output stream (M_DATA_WIDTH), all outputs registered
// Optional feature: define AXIS_DOWNSIZER_EARLY_LAST_EN to stop a word after
// its highest segment carrying any tkeep bit (only when KEEP_ENABLE=1);
// otherwise every word produces RATIO beats.
module axis_downsizer #(
    parameter int S_DATA_WIDTH = 32,
    parameter int M_DATA_WIDTH = 8,
    parameter int KEEP_ENABLE  = (S_DATA_WIDTH > 8),
    parameter int USER_ENABLE  = 1,
    parameter int USER_WIDTH   = 1
) (
    input logic         clk,
    input logic         arst,
    axis_downsizer_if.slave  s_axis,
    axis_downsizer_if.master m_axis
);
    localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
    localparam int MK    = M_DATA_WIDTH / 8;
    localparam int SEG_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                           state;
    logic [SEG_W-1:0]                 seg, seg_nxt, last_seg_r, last_seg_in;
    logic [RATIO-1:0][M_DATA_WIDTH-1:0] data_r, data_in;
    logic [RATIO-1:0][MK-1:0]         keep_r, keep_in;
    logic                             last_r;
    logic [USER_WIDTH-1:0]            user_r, user_in;
    logic [M_DATA_WIDTH-1:0]          m_data_q;
    logic [MK-1:0]                    m_keep_q;
    logic                             m_valid_q, m_last_q;
    logic                             seg_at_end, s_ready, s_hs, m_hs;

    assign data_in = s_axis.tdata;
    assign keep_in = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;
    assign user_in = (USER_ENABLE != 0) ? s_axis.tuser : '0;

    // Index of the final segment to emit for the incoming word.
`ifdef AXIS_DOWNSIZER_EARLY_LAST_EN
    always_comb begin
        last_seg_in = SEG_W'(RATIO - 1);
        if (KEEP_ENABLE != 0) begin
            last_seg_in = '0;
            for (int i = 1; i < RATIO; i++)
                if (|keep_in[i]) last_seg_in = SEG_W'(i);
        end
    end
`else
    assign last_seg_in = SEG_W'(RATIO - 1);
`endif

    assign seg_nxt    = seg + 1'b1;
    assign seg_at_end = (seg == last_seg_r);
    // Accept a new word when idle, or on the cycle the final beat leaves, so
    // consecutive words stream without a bubble.
    assign s_ready    = !arst && (state == IDLE || (seg_at_end && m_axis.tready));
    assign s_hs       = s_axis.tvalid && s_ready;
    assign m_hs       = m_valid_q && m_axis.tready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            seg        <= '0;
            last_seg_r <= '0;
            data_r     <= '0;
            keep_r     <= '0;
            last_r     <= 1'b0;
            user_r     <= '0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_valid_q  <= 1'b0;
            m_last_q   <= 1'b0;
        end else if (s_hs) begin
            state      <= SEND;
            seg        <= '0;
            last_seg_r <= last_seg_in;
            data_r     <= data_in;
            keep_r     <= keep_in;
            last_r     <= s_axis.tlast;
            user_r     <= user_in;
            m_data_q   <= data_in[0];
            m_keep_q   <= keep_in[0];
            m_valid_q  <= 1'b1;
            m_last_q   <= s_axis.tlast && (last_seg_in == '0);
        end else if (m_hs) begin
            if (!seg_at_end) begin
                seg      <= seg_nxt;
                m_data_q <= data_r[seg_nxt];
                m_keep_q <= keep_r[seg_nxt];
                m_last_q <= last_r && (seg_nxt == last_seg_r);
            end else begin
                m_valid_q <= 1'b0;
                state     <= IDLE;
            end
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_data_q;
    assign m_axis.tkeep  = m_keep_q;
    assign m_axis.tvalid = m_valid_q;
    assign m_axis.tlast  = m_last_q;
    assign m_axis.tuser  = user_r;  // constant across a word, so replicated on every beat
endmodule

// File: tb/tb_axis_downsizer.sv
module tb_axis_downsizer;
    logic clk  = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    axis_downsizer_if #(.DATA_WIDTH(32), .USER_WIDTH(1)) s  ();
    axis_downsizer_if #(.DATA_WIDTH(8),  .USER_WIDTH(1)) m  ();
    axis_downsizer_if #(.DATA_WIDTH(32), .USER_WIDTH(1)) s2 ();
    axis_downsizer_if #(.DATA_WIDTH(8),  .USER_WIDTH(1)) m2 ();

    axis_downsizer dut (.clk(clk), .arst(arst), .s_axis(s), .m_axis(m));

    // Second instance with the sideband disabled, fed the same input stream.
    axis_downsizer #(.USER_ENABLE(0)) dut_nouser (.clk(clk), .arst(arst), .s_axis(s2), .m_axis(m2));
    assign s2.tdata  = s.tdata;
    assign s2.tkeep  = s.tkeep;
    assign s2.tvalid = s.tvalid;
    assign s2.tlast  = s.tlast;
    assign s2.tuser  = s.tuser;
    assign m2.tready = 1'b1;

    typedef struct {
        logic [7:0] d;
        logic       k;
        logic       l;
        logic       u;
        logic       endw;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad   = 0;
    int pops  = 0;
    bit rnd_rdy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: byte i of the word is beat i; with early-last, beats stop at
    // the highest byte whose keep bit is set (at least one beat).
    task automatic model_push(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u);
        int n;
        beat_t b;
        n = 4;
`ifdef AXIS_DOWNSIZER_EARLY_LAST_EN
        n = 1;
        for (int i = 0; i < 4; i++) if (((k >> i) & 4'h1) != 0) n = i + 1;
`endif
        for (int i = 0; i < n; i++) begin
            b.d    = 8'((d >> (8 * i)) & 32'hFF);
            b.k    = 1'((k >> i) & 4'h1);
            b.l    = l && (i == n - 1);
            b.u    = u;
            b.endw = (i == n - 1);
            q.push_back(b);
        end
    endtask

    // Called at a posedge; returns at the posedge where the word was taken.
    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l, input logic u, input int gap);
        bit hs;
        bit done;
        done = 1'b0;
        #1;
        s.tdata = d; s.tkeep = k; s.tlast = l; s.tuser = u; s.tvalid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            hs = s.tvalid && s.tready;
            @(posedge clk);
            if (hs) begin
                model_push(d, k, l, u);
                done = 1'b1;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL s_handshake_timeout data=%h", d);
        end
        if (gap > 0) begin
            #1 s.tvalid = 1'b0;
            repeat (gap) @(posedge clk);
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 500 && q.size() != 0; c++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("drain_leftover", 32'(q.size()), 32'd0);
    endtask

    // Output ready driver.
    initial begin
        m.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 m.tready = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_k, prev_l, prev_u;
    always @(negedge clk) begin
        if (arst) begin
            chk("rst_m_tvalid", 32'(m.tvalid), 32'd0);
            chk("rst_s_tready", 32'(s.tready), 32'd0);
            prev_stall = 1'b0;
        end else if (!m.tvalid) begin
            chk("bubble_or_latency", 32'(q.size()), 32'd0);
            chk("idle_s_tready", 32'(s.tready), 32'd1);
            prev_stall = 1'b0;
        end else if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL extra_beat actual=%h expected=none", m.tdata);
        end else begin
            chk("m_tdata", 32'(m.tdata), 32'(q[0].d));
            chk("m_tkeep", 32'(m.tkeep), 32'(q[0].k));
            chk("m_tlast", 32'(m.tlast), 32'(q[0].l));
            chk("m_tuser", 32'(m.tuser), 32'(q[0].u));
            chk("send_s_tready", 32'(s.tready), 32'(q[0].endw && m.tready));
            if (prev_stall)
                chk("stall_hold", {m.tdata, 5'd0, m.tkeep, m.tlast, m.tuser},
                                  {prev_d, 5'd0, prev_k, prev_l, prev_u});
            prev_d = m.tdata; prev_k = m.tkeep; prev_l = m.tlast; prev_u = m.tuser;
            prev_stall = !m.tready;
            if (m.tready) begin
                void'(q.pop_front());
                pops++;
            end
        end
        if (!arst && m2.tvalid) chk("nouser_tuser", 32'(m2.tuser), 32'd0);
    end

    initial begin
        int p0;
        logic [3:0] k;
        s.tvalid = 1'b0; s.tdata = '0; s.tkeep = '0; s.tlast = 1'b0; s.tuser = 1'b0;
        #1 arst = 1'b1;
        @(negedge clk);
        chk("rst_m_tdata", 32'(m.tdata), 32'd0);
        chk("rst_m_tkeep", 32'(m.tkeep), 32'd0);
        chk("rst_m_tlast", 32'(m.tlast), 32'd0);
        chk("rst_m_tuser", 32'(m.tuser), 32'd0);
        repeat (2) @(posedge clk);
        #1 arst = 1'b0;
        @(posedge clk);

        send(32'hDDCCBBAA, 4'hF, 1'b1, 1'b0, 1);
        drain();
        send(32'h44332211, 4'hF, 1'b0, 1'b0, 0);
        send(32'h88776655, 4'hF, 1'b1, 1'b0, 1);
        drain();
        send(32'hDDCCBBAA, 4'hF, 1'b1, 1'b1, 1);
        drain();
        send(32'h000000AA, 4'h1, 1'b1, 1'b0, 1);
        drain();
        send(32'h12345678, 4'h0, 1'b1, 1'b1, 1);
        drain();

        // Reset in the middle of a word: after beat BB leaves.
        send(32'hDDCCBBAA, 4'hF, 1'b1, 1'b0, 0);
        #1 s.tvalid = 1'b0;
        p0 = pops;
        for (int c = 0; c < 50 && pops < p0 + 2; c++) @(posedge clk);
        #1 arst = 1'b1;
        q.delete();
        #1 chk("async_rst_m_tvalid", 32'(m.tvalid), 32'd0);
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;
        @(posedge clk);
        send(32'h11223344, 4'hF, 1'b1, 1'b0, 1);
        drain();

        // Random words with random output stalls.
        rnd_rdy = 1'b1;
        for (int w = 0; w < 60; w++) begin
            k = 4'($urandom_range(0, 15));
            if (w % 3 != 0) k = 4'hF;
            send($urandom, k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2));
        end
        #1 s.tvalid = 1'b0;
        drain();
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
